ifu_fetch: RTL
==============

Name: ifu_fetch

Overview:
- Multi-cycle instruction fetch unit. It sits directly upstream of the decoder/execute datapath.
- Holds the architectural PC and issues one read per instruction on a valid/ready memory bus. It presents the fetched 32-bit instruction, with its PC, to decode.
- It waits for execute to commit and return the next PC before fetching again. There is no speculation and at most one outstanding bus transaction.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
- ADDR_W, 64, bus address and PC width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- araddr  out  64  fetch address; always equals pc.
- arvalid  out  1  read request valid.
- arready  in  1  memory accepts request.
- rdata  in  64  read data, 64-bit aligned doubleword.
- rresp  in  2  response status; 2'b00 = OK, anything else = error.
- rvalid  in  1  read data valid.
- rready  out  1  fetch unit accepts response.
- pc  out  64  PC of the presented instruction.
- inst  out  32  fetched instruction.
- inst_valid  out  1  inst/pc/fault valid for decode.
- inst_fault  out  1  presented slot is a fetch fault.
- fault_cause  out  4  4'd0 = instruction address misaligned; 4'd1 = instruction access fault.
- commit  in  1  execute retires the presented slot.
- next_pc  in  64  PC to fetch next; sampled only with commit.
- inst_cnt  out  64  count of committed slots.

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - state=IDLE, pc=RESET_PC, arvalid=0, rready=0.
  - inst_valid=0, inst=0, inst_fault=0, fault_cause=0, inst_cnt=0.
- States: IDLE, REQ, WAIT, VALID. All outputs are registered except araddr=pc and rready=(state==WAIT).
- IDLE → REQ unconditionally on the first clk edge after reset release.
- REQ:
  - arvalid=1, araddr=pc.
  - araddr and arvalid must stay stable until arready; arvalid never drops without a handshake.
  - On arvalid&&arready → WAIT, arvalid=0.
- WAIT:
  - rready=1.
  - On rvalid: inst = pc[2] ? rdata[63:32] : rdata[31:0].
  - If rresp==0: inst_fault=0.
  - Else: inst_fault=1, fault_cause=1, inst=32'h0000_0013.
  - Then → VALID with inst_valid=1.
  - rvalid outside WAIT is ignored (rready=0).
- VALID:
  - inst_valid=1; pc, inst and fault fields held stable until commit.
  - On commit:
    - pc<=next_pc, inst_cnt<=inst_cnt+1 (wraps modulo 2^64).
    - If next_pc[1:0]!=0: stay in VALID for the new slot with inst_fault=1, fault_cause=0, inst=32'h0000_0013. inst_valid stays 1. No bus request is made.
    - Else: → REQ, inst_valid=0, inst_fault=0.
  - next_pc[1:0]==2'b10 counts as misaligned; the core has no C extension.
- commit outside VALID is ignored: no pc update, no count.
- Latency, zero-wait memory:
  - Commit at edge N → arvalid high during cycle N+1.
  - arready=1 → handshake at edge N+1.
  - rvalid=1 in cycle N+2 → inst_valid high from edge N+2.
  - This gives 2 cycles from commit to the next valid instruction.
- RESET_PC misaligned: this is a configuration error and is not checked.
- Reset mid-transaction: the state machine returns to IDLE immediately. A late response from the aborted transaction is not accepted, because rready=0 until the new WAIT. The bus must discard it.

Test Plan:
- Reset release, arready=1, next-cycle rvalid=1, rdata=64'h00500093_00000013, rresp=0:
  - Expect araddr=0x80000000 with arvalid for exactly 1 cycle.
  - Expect inst=0x00000013, pc=0x80000000, inst_valid=1, inst_fault=0.
- Hold arready=0 for 3 cycles in REQ:
  - arvalid=1 and araddr=0x80000000 stable all 3 cycles.
  - Handshake on the 4th cycle; then WAIT with rready=1.
- From VALID, pulse commit with next_pc=0x80000004, same rdata:
  - inst=0x00500093, pc=0x80000004, inst_cnt=1.
  - inst_valid low for exactly 2 cycles with zero-wait memory.
- Commit with next_pc=0x80000002:
  - No arvalid.
  - Next cycle: inst_valid=1, inst_fault=1, fault_cause=0, pc=0x80000002, inst=0x00000013.
- Response with rresp=2'b10:
  - inst_fault=1, fault_cause=1, inst=0x00000013.
  - A following commit with next_pc=0x80000008 clears inst_fault and issues REQ.
- Assert rst low asynchronously mid-WAIT:
  - All outputs reach reset values without a clock edge.
  - rvalid pulse during reset is ignored.
  - After release, fetch restarts at 0x80000000 and inst_cnt=0.
- Commit pulsed while inst_valid=0:
  - pc and inst_cnt unchanged.

Source files
------------

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - multi-cycle, non-speculative instruction fetch unit
//
// Holds the architectural PC and issues one read per instruction on a
// valid/ready memory bus. The fetched 32-bit instruction is presented to
// decode together with its PC. The next fetch starts only after execute
// commits the presented slot and returns the next PC. At most one bus
// transaction is ever outstanding.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   araddr/arvalid/arready   read request channel (araddr always equals pc)
//   rdata/rresp/rvalid/rready read response channel (64-bit doubleword)
//   pc/inst/inst_valid       presented slot towards decode
//   inst_fault/fault_cause   fault status of the presented slot
//   commit/next_pc           retire handshake from execute
//   inst_cnt                 number of committed slots
module ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          ADDR_W   = 64
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [63:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       inst,
    output logic              inst_valid,
    output logic              inst_fault,
    output logic [3:0]        fault_cause,
    input  logic              commit,
    input  logic [ADDR_W-1:0] next_pc,
    output logic [63:0]       inst_cnt
);

    // Canonical NOP (addi x0, x0, 0) placed in the slot when it carries a fault.
    localparam logic [31:0] NOP_INST        = 32'h0000_0013;
    localparam logic [3:0]  CAUSE_MISALIGN  = 4'd0;
    localparam logic [3:0]  CAUSE_ACCESS    = 4'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              arvalid_q, arvalid_d;
    logic [31:0]       inst_q, inst_d;
    logic              inst_valid_q, inst_valid_d;
    logic              inst_fault_q, inst_fault_d;
    logic [3:0]        fault_cause_q, fault_cause_d;
    logic [63:0]       inst_cnt_q, inst_cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC[ADDR_W-1:0];
            arvalid_q     <= 1'b0;
            inst_q        <= 32'h0;
            inst_valid_q  <= 1'b0;
            inst_fault_q  <= 1'b0;
            fault_cause_q <= 4'd0;
            inst_cnt_q    <= 64'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            arvalid_q     <= arvalid_d;
            inst_q        <= inst_d;
            inst_valid_q  <= inst_valid_d;
            inst_fault_q  <= inst_fault_d;
            fault_cause_q <= fault_cause_d;
            inst_cnt_q    <= inst_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        arvalid_d     = arvalid_q;
        inst_d        = inst_q;
        inst_valid_d  = inst_valid_q;
        inst_fault_d  = inst_fault_q;
        fault_cause_d = fault_cause_q;
        inst_cnt_d    = inst_cnt_q;

        case (state_q)
            IDLE: begin
                // arvalid is registered, so it is raised on the way into REQ.
                state_d   = REQ;
                arvalid_d = 1'b1;
            end
            REQ: begin
                // Request stays up, address unchanged, until accepted.
                if (arready) begin
                    state_d   = WAIT;
                    arvalid_d = 1'b0;
                end
            end
            WAIT: begin
                if (rvalid) begin
                    state_d      = VALID;
                    inst_valid_d = 1'b1;
                    if (rresp == 2'b00) begin
                        // pc[2] picks the 32-bit half of the aligned doubleword.
                        inst_d        = pc_q[2] ? rdata[63:32] : rdata[31:0];
                        inst_fault_d  = 1'b0;
                        fault_cause_d = 4'd0;
                    end else begin
                        inst_d        = NOP_INST;
                        inst_fault_d  = 1'b1;
                        fault_cause_d = CAUSE_ACCESS;
                    end
                end
            end
            VALID: begin
                if (commit) begin
                    pc_d       = next_pc;
                    inst_cnt_d = inst_cnt_q + 64'd1;
                    // No compressed instructions, so any nonzero low bit pair
                    // is misaligned; the fault slot is produced without a bus access.
                    if (next_pc[1:0] != 2'b00) begin
                        inst_d        = NOP_INST;
                        inst_fault_d  = 1'b1;
                        fault_cause_d = CAUSE_MISALIGN;
                        inst_valid_d  = 1'b1;
                    end else begin
                        state_d      = REQ;
                        arvalid_d    = 1'b1;
                        inst_valid_d = 1'b0;
                        inst_fault_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign araddr      = pc_q;
    assign arvalid     = arvalid_q;
    assign rready      = (state_q == WAIT);
    assign pc          = pc_q;
    assign inst        = inst_q;
    assign inst_valid  = inst_valid_q;
    assign inst_fault  = inst_fault_q;
    assign fault_cause = fault_cause_q;
    assign inst_cnt    = inst_cnt_q;

endmodule
